// File: rtl/AU_inc_gray.sv
// Gray-code incrementer: o_gray is the modulo-2^WIDTH successor of i_gray.
// ARCH 1 toggles one bit chosen by parity; ARCH 0 and 2 go through binary.
module AU_inc_gray #(
    parameter int WIDTH = 4,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_gray
);
    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    generate
        if (ARCH == 1) begin : g_parity
            logic w_found;
            // Even parity flips bit 0; odd parity flips the bit above the
            // lowest set bit, or the MSB when that bit is already the MSB.
            always_comb begin
                o_gray  = i_gray;
                w_found = 1'b0;
                if (!(^i_gray)) begin
                    o_gray[0] = ~i_gray[0];
                end else begin
                    for (int i = 0; i < WIDTH - 1; i++) begin
                        if (!w_found && i_gray[i]) begin
                            o_gray[i+1] = ~i_gray[i+1];
                            w_found     = 1'b1;
                        end
                    end
                    if (!w_found) o_gray[WIDTH-1] = ~i_gray[WIDTH-1];
                end
            end
        end else begin : g_binary
            logic [WIDTH-1:0] w_bin_inc;
            assign w_bin_inc = g2b(i_gray) + 1'b1;
            assign o_gray    = w_bin_inc ^ (w_bin_inc >> 1);
        end
    endgenerate
endmodule

// File: rtl/au_gray_fifo_ptr.sv
// Gray-coded read/write pointer and flag controller for a 2^ADDR_WIDTH-entry
// synchronous FIFO; flags and count are registered from next-state pointers.
module au_gray_fifo_ptr #(
    parameter int ADDR_WIDTH = 4,
    parameter int ARCH       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    output logic                  push_ok,
    output logic                  pop_ok,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf,
    output logic                  udf
);
    localparam int PTR_W = ADDR_WIDTH + 1;
    // Full means the pointers differ only in their top two Gray bits.
    localparam logic [PTR_W-1:0] FULL_MASK = {PTR_W{1'b1}} << (PTR_W - 2);

    generate
        if (ADDR_WIDTH < 1) begin : g_bad_aw
            $fatal(1, "au_gray_fifo_ptr: ADDR_WIDTH must be >= 1");
        end
        if (ARCH < 0 || ARCH > 2) begin : g_bad_arch
            $fatal(1, "au_gray_fifo_ptr: ARCH must be 0..2");
        end
    endgenerate

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [PTR_W-1:0] r_wr_g, r_rd_g, r_count;
    logic             r_full, r_empty, r_ovf, r_udf;
    logic [PTR_W-1:0] w_wr_inc, w_rd_inc, w_wr_nxt, w_rd_nxt;
    logic             w_push_ok, w_pop_ok;

    AU_inc_gray #(.WIDTH(PTR_W), .ARCH(ARCH)) u_inc_wr (.i_gray(r_wr_g), .o_gray(w_wr_inc));
    AU_inc_gray #(.WIDTH(PTR_W), .ARCH(ARCH)) u_inc_rd (.i_gray(r_rd_g), .o_gray(w_rd_inc));

    assign w_push_ok = push & ~r_full;
    assign w_pop_ok  = pop & ~r_empty;
    assign w_wr_nxt  = w_push_ok ? w_wr_inc : r_wr_g;
    assign w_rd_nxt  = w_pop_ok  ? w_rd_inc : r_rd_g;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_g  <= '0;
            r_rd_g  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (clr) begin
            r_wr_g  <= '0;
            r_rd_g  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_wr_g  <= w_wr_nxt;
            r_rd_g  <= w_rd_nxt;
            r_count <= gray2bin(w_wr_nxt) - gray2bin(w_rd_nxt);
            r_full  <= (w_wr_nxt == (w_rd_nxt ^ FULL_MASK));
            r_empty <= (w_wr_nxt == w_rd_nxt);
            r_ovf   <= r_ovf | (push & r_full);
            r_udf   <= r_udf | (pop & r_empty);
        end
    end

    assign push_ok     = w_push_ok;
    assign pop_ok      = w_pop_ok;
    assign wr_addr     = ADDR_WIDTH'(gray2bin(r_wr_g));
    assign rd_addr     = ADDR_WIDTH'(gray2bin(r_rd_g));
    assign wr_ptr_gray = r_wr_g;
    assign rd_ptr_gray = r_rd_g;
    assign full        = r_full;
    assign empty       = r_empty;
    assign count       = r_count;
    assign ovf         = r_ovf;
    assign udf         = r_udf;
endmodule
